// File: rtl/gg_pkg.sv
// Shared types for the guess-grader history log.
// Holds the log depth, the entry record and the log FSM states.
package gg_pkg;

  localparam int DEPTH = 8;
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [11:0] guess;
    logic [3:0]  znarly;
    logic [3:0]  zood;
    logic [3:0]  round;
  } hist_entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    LOG,
    FROZEN
  } hist_state_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Raw button -> 2-FF synchronizer -> one-cycle rising-edge pulse.
// Ports: clk, reset (sync, high), btn (async raw), pulse (one cycle per press).
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  // High only on the first synchronized cycle of a press.
  assign pulse = s2 & ~prev;

endmodule

// File: rtl/guess_history_log.sv
// Eight-entry log of graded rounds with button scrolling and registered view.
// Ports: CLOCK_50, reset, resetMaster, gradeDone, guessLatched, Znarly, Zood,
//   GameOver, scrollUp, scrollDown -> view*, entryCount, overflowErr.
module guess_history_log
  import gg_pkg::*;
#(
  parameter int DEPTH = gg_pkg::DEPTH,
  parameter int IDX_W = gg_pkg::IDX_W
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        resetMaster,
  input  logic        gradeDone,
  input  logic [11:0] guessLatched,
  input  logic [3:0]  Znarly,
  input  logic [3:0]  Zood,
  input  logic        GameOver,
  input  logic        scrollUp,
  input  logic        scrollDown,
  output logic [11:0] viewGuess,
  output logic [3:0]  viewZnarly,
  output logic [3:0]  viewZood,
  output logic [3:0]  viewRound,
  output logic        viewValid,
  output logic [3:0]  entryCount,
  output logic        overflowErr
);

  localparam logic [3:0]       FULL = 4'(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  hist_state_t state;
  hist_state_t nstate;

  hist_entry_t      mem [DEPTH];
  logic [3:0]       count;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic up_p;
  logic dn_p;
  logic clr;
  logic grade_live;
  logic wr_en;
  logic ovf_hit;
  logic scroll_ok;
  logic sel_valid;
  hist_entry_t sel;

  btn_edge_sync u_up (
    .clk   (CLOCK_50),
    .reset (reset),
    .btn   (scrollUp),
    .pulse (up_p)
  );

  btn_edge_sync u_dn (
    .clk   (CLOCK_50),
    .reset (reset),
    .btn   (scrollDown),
    .pulse (dn_p)
  );

  assign clr        = reset | resetMaster;
  assign grade_live = gradeDone & (state != FROZEN);
  assign wr_en      = grade_live & (count != FULL);
  assign ovf_hit    = grade_live & (count == FULL);
  // A live gradeDone owns rdIdx this cycle, so a scroll is dropped.
  assign scroll_ok  = (state != EMPTY) & ~grade_live;

  assign sel       = mem[rd_idx];
  assign sel_valid = (count != 4'd0) & (4'(rd_idx) < count);

  assign entryCount = count;

  always_comb begin
    nstate = state;
    unique case (state)
      EMPTY:   if (wr_en) nstate = LOG;
      LOG:     if (GameOver) nstate = FROZEN;
      FROZEN:  nstate = FROZEN;
      default: nstate = EMPTY;
    endcase
    if (resetMaster) nstate = EMPTY;
  end

  always_ff @(posedge CLOCK_50) begin
    if (clr) begin
      state       <= EMPTY;
      count       <= 4'd0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      overflowErr <= 1'b0;
      viewGuess   <= 12'd0;
      viewZnarly  <= 4'd0;
      viewZood    <= 4'd0;
      viewRound   <= 4'd0;
      viewValid   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= nstate;
      if (wr_en) begin
        mem[wr_idx] <= '{guess:  guessLatched,
                         znarly: Znarly,
                         zood:   Zood,
                         round:  count + 4'd1};
        count  <= count + 4'd1;
        rd_idx <= wr_idx;
        if (wr_idx != LAST) wr_idx <= wr_idx + 1'b1;
      end else if (scroll_ok) begin
        if (up_p && !dn_p && rd_idx != '0)
          rd_idx <= rd_idx - 1'b1;
        else if (dn_p && !up_p && (4'(rd_idx) < count - 4'd1))
          rd_idx <= rd_idx + 1'b1;
      end
      if (ovf_hit) overflowErr <= 1'b1;
      viewGuess  <= sel_valid ? sel.guess  : 12'd0;
      viewZnarly <= sel_valid ? sel.znarly : 4'd0;
      viewZood   <= sel_valid ? sel.zood   : 4'd0;
      viewRound  <= sel_valid ? 4'(rd_idx) + 4'd1 : 4'd0;
      viewValid  <= sel_valid;
    end
  end

endmodule

// File: tb/tb_guess_history_log.sv
// Directed bench for guess_history_log.
// Model-driven expectations queued per step and compared on the view outputs.
module tb_guess_history_log;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        resetMaster = 1'b0;
  logic        gradeDone = 1'b0;
  logic [11:0] guessLatched = '0;
  logic [3:0]  Znarly = '0;
  logic [3:0]  Zood = '0;
  logic        GameOver = 1'b0;
  logic        scrollUp = 1'b0;
  logic        scrollDown = 1'b0;
  logic [11:0] viewGuess;
  logic [3:0]  viewZnarly;
  logic [3:0]  viewZood;
  logic [3:0]  viewRound;
  logic        viewValid;
  logic [3:0]  entryCount;
  logic        overflowErr;

  guess_history_log dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .resetMaster  (resetMaster),
    .gradeDone    (gradeDone),
    .guessLatched (guessLatched),
    .Znarly       (Znarly),
    .Zood         (Zood),
    .GameOver     (GameOver),
    .scrollUp     (scrollUp),
    .scrollDown   (scrollDown),
    .viewGuess    (viewGuess),
    .viewZnarly   (viewZnarly),
    .viewZood     (viewZood),
    .viewRound    (viewRound),
    .viewValid    (viewValid),
    .entryCount   (entryCount),
    .overflowErr  (overflowErr)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [11:0] g;
    logic [3:0]  zn;
    logic [3:0]  zd;
    logic [3:0]  rnd;
    logic [3:0]  cnt;
    logic        v;
    logic        ovf;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int failures = 0;

  logic [11:0] m_g [8];
  logic [3:0]  m_zn [8];
  logic [3:0]  m_zd [8];
  int m_cnt;
  int m_rd;
  bit m_frozen;
  bit m_ovf;

  task automatic model_clear();
    m_cnt = 0;
    m_rd = 0;
    m_frozen = 0;
    m_ovf = 0;
    for (int i = 0; i < 8; i++) begin
      m_g[i] = '0;
      m_zn[i] = '0;
      m_zd[i] = '0;
    end
  endtask

  task automatic cmp(string tag, logic [15:0] act, logic [15:0] expv);
    checks++;
    assert (act === expv) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, act, expv);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.v = (m_cnt > 0);
    e.cnt = 4'(m_cnt);
    e.ovf = m_ovf;
    if (e.v) begin
      e.g = m_g[m_rd];
      e.zn = m_zn[m_rd];
      e.zd = m_zd[m_rd];
      e.rnd = 4'(m_rd + 1);
    end else begin
      e.g = '0;
      e.zn = '0;
      e.zd = '0;
      e.rnd = '0;
    end
    q.push_back(e);
  endtask

  // Called right after the negedge following the last state-changing edge;
  // the registered view must be current one edge later.
  task automatic check(string tag);
    exp_t e;
    push_exp();
    @(negedge CLOCK_50);
    e = q.pop_front();
    cmp({tag, ".guess"}, 16'(viewGuess), 16'(e.g));
    cmp({tag, ".zn"}, 16'(viewZnarly), 16'(e.zn));
    cmp({tag, ".zd"}, 16'(viewZood), 16'(e.zd));
    cmp({tag, ".round"}, 16'(viewRound), 16'(e.rnd));
    cmp({tag, ".valid"}, 16'(viewValid), 16'(e.v));
    cmp({tag, ".count"}, 16'(entryCount), 16'(e.cnt));
    cmp({tag, ".ovf"}, 16'(overflowErr), 16'(e.ovf));
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic model_grade(logic [11:0] g, logic [3:0] zn,
                             logic [3:0] zd);
    if (!m_frozen) begin
      if (m_cnt < 8) begin
        m_g[m_cnt] = g;
        m_zn[m_cnt] = zn;
        m_zd[m_cnt] = zd;
        m_rd = m_cnt;
        m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic grade(logic [11:0] g, logic [3:0] zn, logic [3:0] zd);
    @(negedge CLOCK_50);
    guessLatched = g;
    Znarly = zn;
    Zood = zd;
    gradeDone = 1'b1;
    @(negedge CLOCK_50);
    gradeDone = 1'b0;
    model_grade(g, zn, zd);
  endtask

  task automatic press(bit up, int hold);
    @(negedge CLOCK_50);
    if (up) scrollUp = 1'b1;
    else scrollDown = 1'b1;
    repeat (hold) @(negedge CLOCK_50);
    scrollUp = 1'b0;
    scrollDown = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    if (m_cnt > 0) begin
      if (up && m_rd > 0) m_rd--;
      if (!up && m_rd < m_cnt - 1) m_rd++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    do_reset();
    check("reset");

    // 1: single write shows up two edges after gradeDone
    grade(12'o1234, 4'd1, 4'd2);
    check("t1_write");

    // 2: scroll through three entries with saturation
    do_reset();
    grade(12'o0123, 4'd0, 4'd1);
    grade(12'o4567, 4'd2, 4'd1);
    grade(12'o7012, 4'd3, 4'd0);
    check("t2_three");
    press(1'b1, 6);
    check("t2_up1");
    press(1'b1, 6);
    check("t2_up2");
    press(1'b1, 6);
    check("t2_up_sat");
    for (int i = 0; i < 5; i++) press(1'b0, 6);
    check("t2_dn_sat");

    // 3: fill the log, then one more grade
    do_reset();
    for (int i = 0; i < 8; i++)
      grade(12'(i * 37 + 5), 4'(i % 5), 4'((i + 1) % 5));
    check("t3_full");
    grade(12'o7777, 4'd4, 4'd0);
    check("t3_overflow");

    // 4: GameOver freezes the log, scrolling still works
    do_reset();
    for (int i = 0; i < 4; i++)
      grade(12'(i * 91 + 3), 4'(i), 4'(3 - i));
    @(negedge CLOCK_50);
    GameOver = 1'b1;
    @(negedge CLOCK_50);
    m_frozen = 1;
    grade(12'o5555, 4'd2, 4'd2);
    check("t4_frozen");
    press(1'b1, 6);
    check("t4_scroll");
    GameOver = 1'b0;

    // 5: resetMaster beats gradeDone
    do_reset();
    for (int i = 0; i < 5; i++)
      grade(12'(i * 13 + 1), 4'(i % 4), 4'(i % 3));
    check("t5_five");
    @(negedge CLOCK_50);
    gradeDone = 1'b1;
    resetMaster = 1'b1;
    guessLatched = 12'o3333;
    @(negedge CLOCK_50);
    gradeDone = 1'b0;
    resetMaster = 1'b0;
    model_clear();
    check("t5_clear");

    // 6: gradeDone wins over a coincident scroll pulse; hold gives one move
    do_reset();
    grade(12'o1111, 4'd1, 4'd0);
    grade(12'o2222, 4'd2, 4'd0);
    grade(12'o3333, 4'd3, 4'd0);
    @(negedge CLOCK_50);
    scrollUp = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    guessLatched = 12'o4444;
    Znarly = 4'd4;
    Zood = 4'd0;
    gradeDone = 1'b1;
    @(negedge CLOCK_50);
    gradeDone = 1'b0;
    model_grade(12'o4444, 4'd4, 4'd0);
    repeat (17) @(negedge CLOCK_50);
    scrollUp = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check("t6_coincide");
    press(1'b1, 20);
    check("t6_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
